march_a: RTL and testbench



---
 rtl/march_a_if.sv | 21 ++
 rtl/march_a.sv | 105 ++++++++++
 tb/tb_march_a.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/march_a_if.sv
// Bus between the March A BIST controller and its surroundings: enable, SRAM
// read data in; SRAM address/data/write-enable and status out.
interface march_a_if;
    logic       en_in;
    logic [3:0] dat_in;
    logic [3:0] dat_out;
    logic [7:0] addr_out;
    logic       w_en_out;
    logic       rst_done;
    logic       err;

    modport slave (
        input  en_in, dat_in,
        output dat_out, addr_out, w_en_out, rst_done, err
    );

    modport master (
        output en_in, dat_in,
        input  dat_out, addr_out, w_en_out, rst_done, err
    );
endinterface

// File: rtl/march_a.sv
// March A BIST controller for a 256 x 4 SRAM: one operation per clock, sticky
// mismatch flag, completion flag held while the enable stays high.
module march_a (
    input  logic      clk,
    input  logic      rst,
    march_a_if.slave  bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_M0   = 3'd1;
    localparam logic [2:0] S_M1   = 3'd2;
    localparam logic [2:0] S_M2   = 3'd3;
    localparam logic [2:0] S_M3   = 3'd4;
    localparam logic [2:0] S_M4   = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0] state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [1:0] op_q, op_d;
    logic       err_q, err_d;

    logic active, op_rd, op_bg, op_last, desc, addr_end;

    // Operation decode: read/write, background bit, last op of the element.
    always_comb begin
        op_rd   = 1'b0;
        op_bg   = 1'b0;
        op_last = 1'b1;
        case (state_q)
            S_M0: begin op_rd = 1'b0;          op_bg = 1'b0;      op_last = 1'b1;          end
            S_M1: begin op_rd = (op_q == 2'd0); op_bg = op_q[0];  op_last = (op_q == 2'd3); end
            S_M2: begin op_rd = (op_q == 2'd0); op_bg = ~op_q[0]; op_last = (op_q == 2'd2); end
            S_M3: begin op_rd = (op_q == 2'd0); op_bg = ~op_q[0]; op_last = (op_q == 2'd3); end
            S_M4: begin op_rd = (op_q == 2'd0); op_bg = op_q[0];  op_last = (op_q == 2'd2); end
            default: ;
        endcase
    end

    assign active   = (state_q >= S_M0) && (state_q <= S_M4);
    assign desc     = (state_q == S_M3) || (state_q == S_M4);
    assign addr_end = desc ? (addr_q == 8'h00) : (addr_q == 8'hFF);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        op_d    = op_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.en_in) begin
                    state_d = S_M0;
                    addr_d  = 8'h00;
                    op_d    = 2'd0;
                    err_d   = 1'b0;
                end
            end
            S_M0, S_M1, S_M2, S_M3, S_M4: begin
                if (!bus.en_in) begin
                    state_d = S_IDLE;
                    addr_d  = 8'h00;
                    op_d    = 2'd0;
                end else begin
                    if (op_rd && (bus.dat_in != {4{op_bg}}))
                        err_d = 1'b1;
                    if (op_last) begin
                        op_d = 2'd0;
                        if (addr_end) begin
                            // M4 + 1 lands on DONE; M3 and M4 start from the top.
                            state_d = state_q + 3'd1;
                            addr_d  = (state_q == S_M2 || state_q == S_M3) ? 8'hFF : 8'h00;
                        end else begin
                            addr_d = desc ? addr_q - 8'd1 : addr_q + 8'd1;
                        end
                    end else begin
                        op_d = op_q + 2'd1;
                    end
                end
            end
            S_DONE: begin
                if (!bus.en_in)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= 8'h00;
            op_q    <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

    assign bus.w_en_out = active & ~op_rd;
    assign bus.dat_out  = (active & ~op_rd) ? {4{op_bg}} : 4'h0;
    assign bus.addr_out = active ? addr_q : 8'h00;
    assign bus.rst_done = (state_q == S_DONE);
    assign bus.err      = err_q;
endmodule

// File: tb/tb_march_a.sv
// Bench for march_a: behavioural SRAM with optional stuck-at fault, expected
// operations queued per cycle from an arithmetic model of the March A sequence.
module tb_march_a;
    logic clk = 1'b0;
    logic rst;
    logic fault;
    int   n_asrt = 0;
    int   n_fail = 0;

    march_a_if bus ();

    march_a dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // SRAM model: synchronous write, combinational read; bit 2 of word 37 can stick at 1.
    logic [3:0] mem [256];
    always @(posedge clk)
        if (bus.w_en_out) mem[bus.addr_out] <= bus.dat_out;
    assign bus.dat_in = (fault && bus.addr_out == 8'd37) ? (mem[bus.addr_out] | 4'b0100)
                                                          : mem[bus.addr_out];

    typedef struct packed {
        logic       w;
        logic [3:0] d;
        logic [7:0] a;
        logic       e;
    } exp_t;

    exp_t sb_q[$];

    function automatic exp_t exp_op(input int k, input bit flt);
        exp_t o;
        int j;
        o.e = flt && (k > 404);
        if (k < 256) begin
            o.w = 1'b1; o.d = 4'h0; o.a = 8'(k);
        end else if (k < 1280) begin
            j = k - 256; o.a = 8'(j / 4);
            case (j % 4)
                0: begin o.w = 1'b0; o.d = 4'h0; end
                1: begin o.w = 1'b1; o.d = 4'hF; end
                2: begin o.w = 1'b1; o.d = 4'h0; end
                default: begin o.w = 1'b1; o.d = 4'hF; end
            endcase
        end else if (k < 2048) begin
            j = k - 1280; o.a = 8'(j / 3);
            case (j % 3)
                0: begin o.w = 1'b0; o.d = 4'h0; end
                1: begin o.w = 1'b1; o.d = 4'h0; end
                default: begin o.w = 1'b1; o.d = 4'hF; end
            endcase
        end else if (k < 3072) begin
            j = k - 2048; o.a = 8'(255 - j / 4);
            case (j % 4)
                0: begin o.w = 1'b0; o.d = 4'h0; end
                1: begin o.w = 1'b1; o.d = 4'h0; end
                2: begin o.w = 1'b1; o.d = 4'hF; end
                default: begin o.w = 1'b1; o.d = 4'h0; end
            endcase
        end else begin
            j = k - 3072; o.a = 8'(255 - j / 3);
            case (j % 3)
                0: begin o.w = 1'b0; o.d = 4'h0; end
                1: begin o.w = 1'b1; o.d = 4'hF; end
                default: begin o.w = 1'b1; o.d = 4'h0; end
            endcase
        end
        return o;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic done_e, input logic err_e);
        check({tag, " w_en/dat/addr"}, {19'd0, bus.w_en_out, bus.dat_out, bus.addr_out}, 32'd0);
        check({tag, " rst_done"}, {31'd0, bus.rst_done}, {31'd0, done_e});
        check({tag, " err"}, {31'd0, bus.err}, {31'd0, err_e});
    endtask

    // Called at a negedge with en_in already high (or running); checks ops k0..k1.
    task automatic run_ops(input int k0, input int k1, input bit flt);
        exp_t e;
        for (int k = k0; k <= k1; k++) begin
            sb_q.push_back(exp_op(k, flt));
            @(negedge clk);
            e = sb_q.pop_front();
            check($sformatf("op k=%0d", k),
                  {19'd0, bus.w_en_out, bus.dat_out, bus.addr_out}, {19'd0, e.w, e.d, e.a});
            check($sformatf("err/done k=%0d", k), {30'd0, bus.err, bus.rst_done}, {30'd0, e.e, 1'b0});
            if (k == 2048)
                check("M3 first read data", {28'd0, bus.dat_in}, 32'hF);
        end
    endtask

    initial begin
        rst = 1'b1;
        fault = 1'b0;
        bus.en_in = 1'b0;

        // Reset and quiet idle
        @(negedge clk);
        check_idle("reset", 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_idle($sformatf("idle c%0d", i), 1'b0, 1'b0);
        end

        // Full fault-free run
        bus.en_in = 1'b1;
        run_ops(0, 3839, 1'b0);
        @(negedge clk);
        check_idle("clean done", 1'b1, 1'b0);
        @(negedge clk);
        check_idle("clean done hold", 1'b1, 1'b0);
        bus.en_in = 1'b0;
        @(negedge clk);
        check_idle("clean back to idle", 1'b0, 1'b0);

        // Stuck-at fault run
        fault = 1'b1;
        bus.en_in = 1'b1;
        run_ops(0, 3839, 1'b1);
        @(negedge clk);
        check_idle("fault done", 1'b1, 1'b1);
        bus.en_in = 1'b0;
        @(negedge clk);
        check_idle("fault idle err held", 1'b0, 1'b1);

        // Abort at k=1000 keeps err, re-enable restarts and clears err
        bus.en_in = 1'b1;
        run_ops(0, 999, 1'b1);
        bus.en_in = 1'b0;
        @(negedge clk);
        check_idle("abort", 1'b0, 1'b1);
        @(negedge clk);
        check_idle("abort idle", 1'b0, 1'b1);
        bus.en_in = 1'b1;
        run_ops(0, 1500, 1'b1);

        // Asynchronous reset mid-M2, away from any clock edge
        rst = 1'b1;
        #1;
        check_idle("async rst", 1'b0, 1'b0);
        bus.en_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("post rst idle", 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
